rv_fpu_req_tracker: RTL

//  Parametrised FPU request tracker between issue and an out-of-order FPU core.
//  - Allocates a tag per accepted request and stores its metadata.
//  - Resolves the rounding mode and reduces per-thread fflags over the active threads.
//  - Keeps a per-warp in-flight count, so pending stays correct with several requests from one warp in flight.
//  - Registers the response towards commit.

---
 rtl/rv_fpu_req_tracker_pkg.sv | 37 +++
 rtl/rv_fpu_req_tracker_tag_alloc.sv | 43 ++++
 rtl/rv_fpu_req_tracker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rv_fpu_req_tracker_pkg.sv
// Shared widths, request metadata layout and the per-lane fflags reducer for the FPU request tracker.
// Each lane's fflags occupy 5 bits, ordered {NV,DZ,OF,UF,NX} from MSB to LSB.
package rv_fpu_req_tracker_pkg;

    localparam int NUM_THREADS = 4;
    localparam int NUM_WARPS   = 4;
    localparam int NW_BITS     = 2;
    localparam int UUID_BITS   = 44;
    localparam int NR_BITS     = 6;
    localparam int FRM_BITS    = 3;
    localparam int FFLAGS_W    = 5;

    localparam logic [FRM_BITS-1:0] FRM_DYN = '1;

    typedef logic [FFLAGS_W-1:0] fflags_t;

    typedef struct packed {
        logic [UUID_BITS-1:0]   uuid;
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            pc;
        logic [NR_BITS-1:0]     rd;
        logic                   wb;
    } req_meta_t;

    // Each flag is ORed independently across the lanes that were active for the request.
    function automatic fflags_t fflags_reduce(input logic [NUM_THREADS-1:0]          tmask,
                                              input logic [NUM_THREADS*FFLAGS_W-1:0] lane_flags);
        fflags_t r;
        r = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (tmask[i]) r = r | lane_flags[i*FFLAGS_W +: FFLAGS_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/rv_fpu_req_tracker_tag_alloc.sv
// Tag free-list: hands out the lowest free slot and frees a slot when its result returns.
// A slot released this cycle becomes allocatable on the next cycle only.
module rv_tag_alloc #(
    parameter int SIZE = 4,
    parameter int TAGW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc_en,
    output logic [TAGW-1:0] alloc_tag,
    input  logic            release_en,
    input  logic [TAGW-1:0] release_tag,
    output logic            full,
    output logic            empty
);

    logic [SIZE-1:0] used;
    logic            found;

    always_comb begin
        alloc_tag = '0;
        found     = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (!used[i] && !found) begin
                alloc_tag = TAGW'(i);
                found     = 1'b1;
            end
        end
    end

    assign full  = &used;
    assign empty = ~|used;

    always_ff @(posedge clk) begin
        if (reset) begin
            used <= '0;
        end else begin
            if (release_en) used[release_tag] <= 1'b0;
            if (alloc_en)   used[alloc_tag]   <= 1'b1;
        end
    end

endmodule

// File: rtl/rv_fpu_req_tracker.sv
// Tracks FPU requests between issue and an out-of-order FPU core: tag allocation, metadata,
// rounding-mode resolution, fflags reduction, registered commit output and per-warp pending counts.
module rv_fpu_req_tracker
    import rv_fpu_req_tracker_pkg::*;
#(
    parameter  int QUEUE_SIZE = 4,
    localparam int TAGW       = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1,
    localparam int CNTW       = $clog2(QUEUE_SIZE + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [UUID_BITS-1:0]            req_uuid,
    input  logic [NW_BITS-1:0]              req_wid,
    input  logic [NUM_THREADS-1:0]          req_tmask,
    input  logic [31:0]                     req_pc,
    input  logic [NR_BITS-1:0]              req_rd,
    input  logic                            req_wb,
    input  logic [FRM_BITS-1:0]             req_op_mod,
    input  logic [FRM_BITS-1:0]             csr_frm,
    output logic [NW_BITS-1:0]              csr_read_wid,
    input  logic [NUM_WARPS-1:0]            csr_pending,
    output logic                            core_valid_in,
    input  logic                            core_ready_in,
    output logic [TAGW-1:0]                 core_tag_in,
    output logic [FRM_BITS-1:0]             core_frm,
    input  logic                            core_valid_out,
    input  logic [TAGW-1:0]                 core_tag_out,
    input  logic [NUM_THREADS*32-1:0]       core_result,
    input  logic                            core_has_fflags,
    input  logic [NUM_THREADS*FFLAGS_W-1:0] core_fflags,
    output logic                            core_ready_out,
    output logic                            cmt_valid,
    output logic [UUID_BITS-1:0]            cmt_uuid,
    output logic [NW_BITS-1:0]              cmt_wid,
    output logic [NUM_THREADS-1:0]          cmt_tmask,
    output logic [31:0]                     cmt_pc,
    output logic [NR_BITS-1:0]              cmt_rd,
    output logic                            cmt_wb,
    output logic [NUM_THREADS*32-1:0]       cmt_data,
    output logic                            cmt_eop,
    input  logic                            cmt_ready,
    output logic                            csr_we,
    output logic [NW_BITS-1:0]              csr_wid,
    output logic [FFLAGS_W-1:0]             csr_fflags,
    output logic [NUM_WARPS-1:0]            pending
);

    logic            full, empty, gate, push, pop, stall, cmt_fire;
    logic [TAGW-1:0] alloc_tag;
    req_meta_t       meta_q [QUEUE_SIZE];
    req_meta_t       rd_meta, cmt_meta;
    logic            has_fflags_r;
    fflags_t         fflags_r;

    rv_tag_alloc #(.SIZE(QUEUE_SIZE), .TAGW(TAGW)) u_tag_alloc (
        .clk         (clk),
        .reset       (reset),
        .alloc_en    (push),
        .alloc_tag   (alloc_tag),
        .release_en  (pop),
        .release_tag (core_tag_out),
        .full        (full),
        .empty       (empty)
    );

    // A warp with a CSR write outstanding must not issue until the new frm is visible.
    assign gate          = ~full & ~csr_pending[req_wid];
    assign req_ready     = core_ready_in & gate;
    assign core_valid_in = req_valid & gate;
    assign push          = req_valid & req_ready;
    assign core_tag_in   = alloc_tag;
    assign core_frm      = (req_op_mod == FRM_DYN) ? csr_frm : req_op_mod;
    assign csr_read_wid  = req_wid;

    always_ff @(posedge clk) begin
        if (push) meta_q[alloc_tag] <= '{uuid: req_uuid, wid: req_wid, tmask: req_tmask,
                                         pc: req_pc, rd: req_rd, wb: req_wb};
    end

    assign rd_meta        = meta_q[core_tag_out];
    assign stall          = cmt_valid & ~cmt_ready;
    assign core_ready_out = ~stall;
    assign pop            = core_valid_out & core_ready_out;
    assign cmt_fire       = cmt_valid & cmt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmt_valid    <= 1'b0;
            cmt_meta     <= '0;
            cmt_data     <= '0;
            has_fflags_r <= 1'b0;
            fflags_r     <= '0;
        end else if (!stall) begin
            cmt_valid    <= core_valid_out;
            cmt_meta     <= rd_meta;
            cmt_data     <= core_result;
            has_fflags_r <= core_has_fflags;
            fflags_r     <= fflags_reduce(rd_meta.tmask, core_fflags);
        end
    end

    assign cmt_uuid   = cmt_meta.uuid;
    assign cmt_wid    = cmt_meta.wid;
    assign cmt_tmask  = cmt_meta.tmask;
    assign cmt_pc     = cmt_meta.pc;
    assign cmt_rd     = cmt_meta.rd;
    assign cmt_wb     = cmt_meta.wb;
    assign cmt_eop    = 1'b1;
    assign csr_we     = cmt_fire & has_fflags_r;
    assign csr_wid    = cmt_wid;
    assign csr_fflags = fflags_r;

    always_ff @(posedge clk) begin
        if (!reset && pop) assert (!empty) else $error("tag released with no tag in flight");
    end

    // Count spans issue to commit, so it covers results parked in the output register too.
    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_cnt
        logic            inc, dec;
        logic [CNTW-1:0] cnt;

        assign inc = push && (req_wid == NW_BITS'(w));
        assign dec = cmt_fire && (cmt_wid == NW_BITS'(w));

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
            end else if (inc && !dec) begin
                cnt <= cnt + CNTW'(1);
            end else if (dec && !inc) begin
                assert (cnt != '0) else $error("pending count underflow on warp %0d", w);
                if (cnt != '0) cnt <= cnt - CNTW'(1);
            end
        end

        assign pending[w] = (cnt != '0);
    end

endmodule
